// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch stage.
package fetch_pkg;

  localparam int unsigned INST_BYTES  = 4;
  localparam int unsigned FETCH_WIDTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: control inputs, Instmem address/data, decode-side instruction pair.
interface fetch_unit_if #(
  parameter int unsigned IMEM_LENGTH = 1024
);
  localparam int unsigned AW = $clog2(IMEM_LENGTH);

  logic          fetch_enable;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] imem_address;
  logic [31:0]   imem_value1;
  logic [31:0]   imem_value2;
  logic          inst0_valid;
  logic          inst1_valid;
  logic [31:0]   inst0;
  logic [31:0]   inst1;
  logic [31:0]   inst0_pc;
  logic [31:0]   inst1_pc;
  logic [1:0]    dec_accept;

  modport master (
    input  fetch_enable, redirect_valid, redirect_pc, imem_value1, imem_value2, dec_accept,
    output imem_address, inst0_valid, inst1_valid, inst0, inst1, inst0_pc, inst1_pc
  );

  modport slave (
    output fetch_enable, redirect_valid, redirect_pc, imem_value1, imem_value2, dec_accept,
    input  imem_address, inst0_valid, inst1_valid, inst0, inst1, inst0_pc, inst1_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue: 2-wide push, 0..2 pop, flush, head/head+1 read ports.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_e0,
  input  fetch_entry_t                 push_e1,
  input  logic [1:0]                   pop,
  output fetch_entry_t                 head0,
  output fetch_entry_t                 head1,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned QW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);
  assign head0   = mem[head];
  assign head1   = mem[head_p1];

  // Flush wins over push and pop; push and pop otherwise both apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail]    <= push_e0;
        mem[tail_p1] <= push_e1;
        tail         <= tail + PW'(2);
      end
      head  <= head + PW'(pop);
      count <= count + (push ? QW'(2) : QW'(0)) - QW'(pop);
    end
  end

  pop_legal_a : assert property (@(posedge clk) disable iff (!rst_n)
    !flush |-> (pop <= 2'd2 && QW'(pop) <= count))
    else $error("fetch_queue: pop of %0d with count %0d", pop, count);

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: owns the PC, pushes Instmem word pairs into the queue, handles redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_LENGTH = 1024,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned AW         = $clog2(IMEM_LENGTH);
  localparam int unsigned QW         = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [31:0] PAIR_BYTES = 32'(INST_BYTES * FETCH_WIDTH);

  logic [31:0]   pc;
  logic          push_c;
  logic [QW-1:0] count;
  fetch_entry_t  e0;
  fetch_entry_t  e1;
  fetch_entry_t  h0;
  fetch_entry_t  h1;

  // Push decision uses pre-pop occupancy so a full queue never overruns.
  assign push_c = bus.fetch_enable && !bus.redirect_valid && (count <= QW'(QUEUE_DEPTH - 2));

  assign e0 = '{pc: pc, inst: bus.imem_value1};
  assign e1 = '{pc: pc + 32'(INST_BYTES), inst: bus.imem_value2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc <= bus.redirect_pc & ~32'h3;
    end else if (push_c) begin
      pc <= pc + PAIR_BYTES;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.redirect_valid),
    .push    (push_c),
    .push_e0 (e0),
    .push_e1 (e1),
    .pop     (bus.dec_accept),
    .head0   (h0),
    .head1   (h1),
    .count   (count)
  );

  assign bus.imem_address = pc[AW-1:0];
  assign bus.inst0_valid  = (count != '0);
  assign bus.inst1_valid  = (count >= QW'(2));
  assign bus.inst0        = h0.inst;
  assign bus.inst1        = h1.inst;
  assign bus.inst0_pc     = h0.pc;
  assign bus.inst1_pc     = h1.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed literal checks.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  fetch_unit_if #(.IMEM_LENGTH(1024)) bus ();
  fetch_unit_if #(.IMEM_LENGTH(64))   busb ();

  fetch_unit #(.IMEM_LENGTH(1024), .RESET_PC(32'h100), .QUEUE_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fetch_unit #(.IMEM_LENGTH(64), .RESET_PC(32'h3C), .QUEUE_DEPTH(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: each word carries its own byte address under an 0xA0 tag.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  assign bus.imem_value1  = word_at(32'(bus.imem_address));
  assign bus.imem_value2  = word_at(32'(10'(bus.imem_address + 10'd4)));
  assign busb.imem_value1 = word_at(32'(busb.imem_address));
  assign busb.imem_value2 = word_at(32'(6'(busb.imem_address + 6'd4)));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of pending {pc,inst} plus the next fetch PC.
  fetch_entry_t mq[$];
  logic [31:0]  mpc;
  bit           m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mpc = 32'h100;
    end else if (bus.redirect_valid) begin
      mq.delete();
      mpc = bus.redirect_pc & ~32'h3;
    end else begin
      m_push = bus.fetch_enable && (mq.size() <= 6);
      repeat (int'(bus.dec_accept)) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back('{pc: mpc, inst: word_at(mpc & 32'h3FF)});
        mq.push_back('{pc: mpc + 32'd4, inst: word_at((mpc + 32'd4) & 32'h3FF)});
        mpc = mpc + 32'd8;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_v0", 32'(bus.inst0_valid), 32'd0);
      chk("rst_v1", 32'(bus.inst1_valid), 32'd0);
      chk("rst_inst0", bus.inst0, 32'd0);
      chk("rst_inst1", bus.inst1, 32'd0);
      chk("rst_pc0", bus.inst0_pc, 32'd0);
      chk("rst_pc1", bus.inst1_pc, 32'd0);
      chk("rst_addr", 32'(bus.imem_address), 32'h100);
    end else begin
      chk("m_addr", 32'(bus.imem_address), mpc & 32'h3FF);
      chk("m_v0", 32'(bus.inst0_valid), 32'(mq.size() >= 1));
      chk("m_v1", 32'(bus.inst1_valid), 32'(mq.size() >= 2));
      if (mq.size() >= 1) begin
        chk("m_inst0", bus.inst0, mq[0].inst);
        chk("m_pc0", bus.inst0_pc, mq[0].pc);
      end
      if (mq.size() >= 2) begin
        chk("m_inst1", bus.inst1, mq[1].inst);
        chk("m_pc1", bus.inst1_pc, mq[1].pc);
      end
    end
  end

  initial begin
    int d;
    int r;
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    bus.fetch_enable = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.dec_accept = 2'd0;
    busb.fetch_enable = 1'b1;
    busb.redirect_valid = 1'b0;
    busb.redirect_pc = 32'd0;
    busb.dec_accept = 2'd0;

    repeat (3) @(negedge clk);
    chk("lit_rst_addr", 32'(bus.imem_address), 32'h100);
    chk("lit_rstb_addr", 32'(busb.imem_address), 32'h3C);
    rst_n = 1'b1;
    bus.fetch_enable = 1'b1;

    // First edge after release delivers the pair at RESET_PC.
    @(negedge clk);
    chk("lit_first_inst0", bus.inst0, 32'hA000_0100);
    chk("lit_first_pc0", bus.inst0_pc, 32'h100);
    chk("lit_first_pc1", bus.inst1_pc, 32'h104);
    chk("lit_first_v1", 32'(bus.inst1_valid), 32'd1);
    chk("lit_b_inst0", busb.inst0, 32'hA000_003C);
    chk("lit_b_inst1", busb.inst1, 32'hA000_0000);
    chk("lit_b_pc1", busb.inst1_pc, 32'h40);
    chk("lit_b_addr", 32'(busb.imem_address), 32'h04);

    // No consumption: four pushes fill the queue, then PC holds.
    repeat (9) @(negedge clk);
    chk("lit_full_addr", 32'(bus.imem_address), 32'h120);
    chk("lit_full_pc1", bus.inst1_pc, 32'h104);

    // Full-rate streaming wraps the queue pointers several times.
    bus.dec_accept = 2'd2;
    repeat (12) @(negedge clk);
    chk("lit_stream_pc0", bus.inst0_pc, 32'h160);
    chk("lit_stream_addr", 32'(bus.imem_address), 32'h178);

    // Redirect coincident with pop-2 and a true push condition.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h206;
    @(negedge clk);
    chk("lit_redir_v0", 32'(bus.inst0_valid), 32'd0);
    chk("lit_redir_v1", 32'(bus.inst1_valid), 32'd0);
    chk("lit_redir_addr", 32'(bus.imem_address), 32'h204);
    bus.redirect_valid = 1'b0;
    bus.dec_accept = 2'd0;
    @(negedge clk);
    chk("lit_redir_pc0", bus.inst0_pc, 32'h204);
    chk("lit_redir_pc1", bus.inst1_pc, 32'h208);
    chk("lit_redir_inst0", bus.inst0, 32'hA000_0204);

    // Fetch disabled: queue drains, PC holds, then resumes.
    repeat (2) @(negedge clk);
    bus.fetch_enable = 1'b0;
    bus.dec_accept = 2'd1;
    repeat (4) @(negedge clk);
    chk("lit_hold_addr", 32'(bus.imem_address), 32'h21C);
    chk("lit_hold_pc0", bus.inst0_pc, 32'h214);
    bus.fetch_enable = 1'b1;
    bus.dec_accept = 2'd0;
    @(negedge clk);
    chk("lit_resume_addr", 32'(bus.imem_address), 32'h224);

    // Mixed traffic with legal pop counts, stalls and redirects.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      d = $urandom_range(0, 2);
      if (d > mq.size()) d = mq.size();
      bus.redirect_valid = (r == 0);
      bus.redirect_pc = 32'($urandom_range(0, 1023));
      bus.fetch_enable = (r != 1);
      bus.dec_accept = 2'(d);
      @(negedge clk);
    end

    // Asynchronous reset in mid-cycle.
    bus.redirect_valid = 1'b0;
    bus.dec_accept = 2'd0;
    bus.fetch_enable = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("lit_async_v0", 32'(bus.inst0_valid), 32'd0);
    chk("lit_async_addr", 32'(bus.imem_address), 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rerun_pc0", bus.inst0_pc, 32'h100);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
